// File: rtl/div_seq.sv
// Sequential restoring divider for DIV/DIVU: 32 iterations, {remainder, quotient} result.
// Define DIV_SIGNED_EN to build signed division; otherwise every divide is unsigned.
module div_seq #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                annul_i,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stallreq_o
);

  // state    | meaning
  // S_FREE   | idle, accepts a request
  // S_BYZERO | divisor was zero, result forced to 0
  // S_ON     | one restoring step per cycle
  // S_END    | result held until start_i drops
  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]    rem_q, rem_d;
  logic [DATA_W-1:0]    quo_q, quo_d;
  logic [DATA_W-1:0]    dsor_q, dsor_d;
  logic [2*DATA_W-1:0]  result_q, result_d;
  logic [DATA_W:0]      rem_shift;
  logic [DATA_W:0]      trial;
  logic [DATA_W-1:0]    mag1, mag2;
  logic [DATA_W-1:0]    quo_fix, rem_fix;

`ifdef DIV_SIGNED_EN
  logic neg_quo_q, neg_quo_d;
  logic neg_rem_q, neg_rem_d;
  logic sgn1, sgn2;

  assign sgn1    = signed_div_i & opdata1_i[DATA_W-1];
  assign sgn2    = signed_div_i & opdata2_i[DATA_W-1];
  assign mag1    = sgn1 ? -opdata1_i : opdata1_i;
  assign mag2    = sgn2 ? -opdata2_i : opdata2_i;
  // Negating 0x80000000 yields itself, so the most-negative / -1 case wraps naturally.
  assign quo_fix = neg_quo_q ? -quo_q : quo_q;
  assign rem_fix = neg_rem_q ? -rem_q : rem_q;
`else
  logic unused_signed;

  assign unused_signed = signed_div_i;
  assign mag1          = opdata1_i;
  assign mag2          = opdata2_i;
  assign quo_fix       = quo_q;
  assign rem_fix       = rem_q;
`endif

  // Partial remainder is below the divisor, so the shifted value needs one extra bit.
  assign rem_shift = {rem_q, quo_q[DATA_W-1]};
  assign trial     = rem_shift - {1'b0, dsor_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dsor_d   = dsor_q;
    result_d = result_q;
`ifdef DIV_SIGNED_EN
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
`endif
    case (state_q)
      S_FREE: begin
        if (start_i && !annul_i) begin
          quo_d    = mag1;
          dsor_d   = mag2;
          rem_d    = '0;
          cnt_d    = '0;
          result_d = '0;
`ifdef DIV_SIGNED_EN
          neg_quo_d = sgn1 ^ sgn2;
          neg_rem_d = sgn1;
`endif
          state_d  = (opdata2_i == '0) ? S_BYZERO : S_ON;
        end
      end
      S_BYZERO: begin
        result_d = '0;
        state_d  = annul_i ? S_FREE : S_END;
      end
      S_ON: begin
        if (annul_i) begin
          cnt_d   = '0;
          state_d = S_FREE;
        end else if (cnt_q == CNT_W'(DATA_W)) begin
          result_d = {rem_fix, quo_fix};
          state_d  = S_END;
        end else begin
          if (!trial[DATA_W]) begin
            rem_d = trial[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b1};
          end else begin
            rem_d = rem_shift[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b0};
          end
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_END: begin
        if (annul_i || !start_i) begin
          result_d = '0;
          state_d  = S_FREE;
        end
      end
      default: state_d = S_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_FREE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dsor_q   <= '0;
      result_q <= '0;
`ifdef DIV_SIGNED_EN
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dsor_q   <= dsor_d;
      result_q <= result_d;
`ifdef DIV_SIGNED_EN
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign ready_o    = (state_q == S_END);
  assign result_o   = ready_o ? result_q : '0;
  assign stallreq_o = start_i & ~ready_o & ~annul_i;

endmodule
